// File: rtl/uart_pkg.sv
// Shared constants for the MMIO UART transmitter: register offsets, STATUS bit
// positions and the serializer state encoding.
package uart_pkg;

  localparam logic [3:0] REG_TXDATA  = 4'h4;
  localparam logic [3:0] REG_STATUS  = 4'h8;
  localparam logic [3:0] REG_BAUDDIV = 4'hC;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_ACTIVE    = 2;
  localparam int STAT_COUNT_LSB = 8;

`ifdef UART_TX_PARITY_EN
  localparam int BAUD_PAR_EN_BIT  = 16;
  localparam int BAUD_PAR_ODD_BIT = 17;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync.sv
// Single-clock FIFO with show-ahead read data; full/empty derive from the
// registered occupancy count, so a push while full is refused even with a pop.
module uart_tx_fifo_sync #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through the count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_fifo_mmio.sv
// MMIO UART transmitter: TXDATA/STATUS/BAUDDIV decode, TX FIFO and frame
// serializer. Define UART_TX_PARITY_EN to add the optional parity bit.
module uart_tx_fifo_mmio
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int DIV_W      = 16,
  parameter int DIV_RESET  = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mmio_req,
  input  logic        mmio_we,
  input  logic [3:0]  mmio_addr,
  input  logic [31:0] mmio_wdata,
  output logic [31:0] mmio_rdata,
  output logic        mmio_ready,
  output logic        uart_tx,
  output logic        tx_irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic [CW-1:0]        fifo_count;

  logic sel_tx, sel_baud;
  assign sel_tx   = mmio_req & (mmio_addr == REG_TXDATA);
  assign sel_baud = mmio_req & (mmio_addr == REG_BAUDDIV);

  // Only a TXDATA write into a full FIFO stalls the bus.
  assign mmio_ready = ~(sel_tx & mmio_we & fifo_full);
  assign fifo_push  = sel_tx & mmio_we & ~fifo_full;

  logic unused_wdata;
  assign unused_wdata = ^mmio_wdata;

  uart_tx_fifo_sync #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (mmio_wdata[DATA_BITS-1:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  logic [DIV_W-1:0] baud_div_q, baud_div_d;
`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d, par_odd_q, par_odd_d;
`endif

  always_comb begin
    baud_div_d = baud_div_q;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
`endif
    if (sel_baud && mmio_we) begin
      baud_div_d = (mmio_wdata[DIV_W-1:0] == '0) ? DIV_W'(1) : mmio_wdata[DIV_W-1:0];
`ifdef UART_TX_PARITY_EN
      par_en_d  = mmio_wdata[BAUD_PAR_EN_BIT];
      par_odd_d = mmio_wdata[BAUD_PAR_ODD_BIT];
`endif
    end
  end

  tx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [DIV_W-1:0]     div_cur_q, div_cur_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 start_frame;
`ifdef UART_TX_PARITY_EN
  logic par_en_cur_q, par_en_cur_d, par_bit_q, par_bit_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_cur_d   = div_cur_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    start_frame = 1'b0;
    fifo_pop    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_cur_d = par_en_cur_q;
    par_bit_d    = par_bit_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) start_frame = 1'b1;
      end
      START: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = div_cur_q - DIV_W'(1);
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = div_cur_q - DIV_W'(1);
          if (idx_q == 3'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = STOP;
`ifdef UART_TX_PARITY_EN
            if (par_en_cur_q) state_d = PARITY;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (cnt_q == '0) begin
          state_d = STOP;
          cnt_d   = div_cur_q - DIV_W'(1);
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == '0) begin
          if (idx_q == 3'(STOP_BITS - 1)) begin
            if (!fifo_empty) start_frame = 1'b1;
            else             state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
            cnt_d = div_cur_q - DIV_W'(1);
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Pop, shift load and divisor latch share the edge into START.
    if (start_frame) begin
      state_d   = START;
      fifo_pop  = 1'b1;
      div_cur_d = baud_div_q;
      cnt_d     = baud_div_q - DIV_W'(1);
      shift_d   = fifo_rdata;
      idx_d     = '0;
`ifdef UART_TX_PARITY_EN
      par_en_cur_d = par_en_q;
      par_bit_d    = (^fifo_rdata) ^ par_odd_q;
`endif
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_bit_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_div_q <= DIV_W'(DIV_RESET);
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_cur_q  <= DIV_W'(DIV_RESET);
      idx_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      par_en_cur_q <= 1'b0;
      par_bit_q    <= 1'b0;
`endif
    end else begin
      baud_div_q <= baud_div_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      par_en_cur_q <= par_en_cur_d;
      par_bit_q    <= par_bit_d;
`endif
    end
  end

  assign uart_tx = tx_q;
  assign tx_irq  = fifo_empty & (state_q == IDLE);

  always_comb begin
    mmio_rdata = '0;
    if (mmio_req && !mmio_we) begin
      case (mmio_addr)
        REG_STATUS: begin
          mmio_rdata[STAT_FULL]             = fifo_full;
          mmio_rdata[STAT_EMPTY]            = fifo_empty;
          mmio_rdata[STAT_ACTIVE]           = (state_q != IDLE);
          mmio_rdata[STAT_COUNT_LSB +: 8]   = 8'(fifo_count);
        end
        REG_BAUDDIV: begin
          mmio_rdata[DIV_W-1:0] = baud_div_q;
`ifdef UART_TX_PARITY_EN
          mmio_rdata[BAUD_PAR_EN_BIT]  = par_en_q;
          mmio_rdata[BAUD_PAR_ODD_BIT] = par_odd_q;
`endif
        end
        default: mmio_rdata = '0;
      endcase
    end
  end

endmodule
